// File: rtl/weight_fifo_to_buf_if.sv
// Handshake bundle between the load FIFO, the tile controller and the weight banks.
// The slave modport is the weight_fifo_to_buf side; master is the surrounding system.
interface weight_fifo_to_buf_if #(
    parameter int DW = 32,
    parameter int AW = 12,
    parameter int Tm = 16
) ();
    logic          wbuf_start;
    logic          wbuf_done;
    logic          busy;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [Tm-1:0] weight_wena;
    logic [AW-1:0] weight_waddr;
    logic [DW-1:0] weight_wdata;

    modport slave (
        input  wbuf_start, fifo_rdata, fifo_empty,
        output wbuf_done, busy, fifo_pop, weight_wena, weight_waddr, weight_wdata
    );

    modport master (
        output wbuf_start, fifo_rdata, fifo_empty,
        input  wbuf_done, busy, fifo_pop, weight_wena, weight_waddr, weight_wdata
    );
endinterface

// File: rtl/weight_fifo_to_buf.sv
// Drains one weight tile (Tn bursts of Tm*K*K words) from the load FIFO into Tm
// weight banks; bank m gets output channel m at address tn*K*K+kk.
module weight_fifo_to_buf #(
    parameter int CW = 16,
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int Tn = 16,
    parameter int Tm = 16,
    parameter int K  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    weight_fifo_to_buf_if.slave  bus
);
    localparam int KK    = K * K;
    localparam int TOTAL = Tn * Tm * KK;
    localparam int BW    = (Tm > 1) ? $clog2(Tm) : 1;
    localparam int XW    = (CW > AW) ? CW : AW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   kk_q, kk_d;
    logic [CW-1:0]   m_q, m_d;
    logic [CW-1:0]   tn_q, tn_d;
    logic [CW-1:0]   pop_cnt_q, pop_cnt_d;
    logic            wr_vld_q, wr_vld_d;
    logic [BW-1:0]   wr_bank_q, wr_bank_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            done_q, done_d;
    logic            pop;
    logic            last_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            kk_q      <= '0;
            m_q       <= '0;
            tn_q      <= '0;
            pop_cnt_q <= '0;
            wr_vld_q  <= 1'b0;
            wr_bank_q <= '0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kk_q      <= kk_d;
            m_q       <= m_d;
            tn_q      <= tn_d;
            pop_cnt_q <= pop_cnt_d;
            wr_vld_q  <= wr_vld_d;
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kk_d      = kk_q;
        m_d       = m_q;
        tn_d      = tn_q;
        pop_cnt_d = pop_cnt_q;
        wr_vld_d  = 1'b0;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;

        // The pop-count guard keeps surplus FIFO words for the next tile.
        pop      = (state_q == RUN) && !bus.fifo_empty && (pop_cnt_q < CW'(TOTAL));
        last_pop = pop && (pop_cnt_q == CW'(TOTAL - 1));

        unique case (state_q)
            IDLE:    if (bus.wbuf_start) state_d = RUN;
            RUN:     if (last_pop) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            wr_vld_d  = 1'b1;
            wr_bank_d = BW'(m_q);
            wr_addr_d = AW'(XW'(tn_q) * XW'(KK) + XW'(kk_q));
            pop_cnt_d = pop_cnt_q + CW'(1);
            if (kk_q == CW'(KK - 1)) begin
                kk_d = '0;
                if (m_q == CW'(Tm - 1)) begin
                    m_d  = '0;
                    tn_d = (tn_q == CW'(Tn - 1)) ? '0 : tn_q + CW'(1);
                end else begin
                    m_d = m_q + CW'(1);
                end
            end else begin
                kk_d = kk_q + CW'(1);
            end
        end

        if (state_q == DONE) begin
            kk_d      = '0;
            m_d       = '0;
            tn_d      = '0;
            pop_cnt_d = '0;
        end

        done_d = (state_d == DONE);
    end

    // Write stage: FIFO data arrives one cycle after the pop, aligned with the request.
    assign bus.fifo_pop     = pop;
    assign bus.busy         = (state_q != IDLE);
    assign bus.wbuf_done    = done_q;
    assign bus.weight_waddr = wr_vld_q ? wr_addr_q : '0;
    assign bus.weight_wdata = wr_vld_q ? bus.fifo_rdata : '0;

    generate
        for (genvar gi = 0; gi < Tm; gi++) begin : g_wena
            assign bus.weight_wena[gi] = wr_vld_q && (wr_bank_q == BW'(gi));
        end
    endgenerate
endmodule
